// File: rtl/clock_display_pkg.sv
// Shared types, constants and the double-dabble step used by the clock display.
package clock_pkg;

   localparam int NUM_DIGITS = 6;
   localparam logic [2:0] LAST_SHIFT = 3'd6;

   typedef enum logic [1:0] {MODE_RUN, MODE_HOUR, MODE_MIN, MODE_SEC} mode_e;
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;

   // Active-low a..g on bits 0..6; codes 10..15 are blank.
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
   };

   // One double-dabble iteration on {tens, units, binary[5:0]}: adjust nibbles, then shift.
   function automatic logic [13:0] dd_step(input logic [13:0] v);
      logic [13:0] t;
      t = v;
      if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
      if (t[9:6] >= 4'd5)   t[9:6]   = t[9:6] + 4'd3;
      return {t[12:0], 1'b0};
   endfunction

endpackage

// File: rtl/clock_display_if.sv
// Time/mode inputs from the clock core and display outputs of clock_display.
interface clock_display_if;
   logic [5:0] second;
   logic [5:0] minute;
   logic [4:0] hour;
   logic [1:0] mode;
   logic [6:0] seg;
   logic [5:0] an;
   logic       conv_busy;

   modport master (output second, minute, hour, mode, input seg, an, conv_busy);
   modport slave  (input second, minute, hour, mode, output seg, an, conv_busy);
endinterface

// File: rtl/clock_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern.
module seg7_decode
   import clock_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);
   assign seg_o = SEG_LUT[bcd_i];
endmodule

// File: rtl/clock_display.sv
// Binary HH:MM:SS -> BCD (sequential double-dabble) -> 6-digit multiplexed 7-segment display.
// Optional macro CLOCK_DISPLAY_BLINK_EN blinks the field selected by mode.
module clock_display
   import clock_pkg::*;
#(
   parameter int CLK_HZ   = 50_000_000,
   parameter int SCAN_HZ  = 1000,
   parameter int BLINK_HZ = 2
) (
   input logic            clk,
   input logic            rst_n,
   clock_display_if.slave bus
);

   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   conv_state_e state_q;
   logic [2:0]  shift_cnt_q;
   logic [16:0] last_q, snap_q;
   logic [13:0] hr_sr_q, mn_sr_q, sc_sr_q;
   logic [23:0] bcd_q;
   logic        busy_q;
   logic [16:0] time_in;

   logic [SCAN_W-1:0] scan_cnt_q;
   logic [2:0]        idx_q;
   logic [5:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d, dec_seg;
   logic [3:0]        digit;
   logic              blank;

   assign time_in = {bus.hour, bus.minute, bus.second};

   // Converter: busy mirrors SHIFT one cycle late so it is high exactly for the 7 cycles before commit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_cnt_q <= '0;
         busy_q      <= 1'b0;
         last_q      <= '1;
         bcd_q       <= '0;
      end else begin
         busy_q <= (state_q == SHIFT);
         case (state_q)
            IDLE: begin
               if (time_in != last_q) begin
                  snap_q      <= time_in;
                  hr_sr_q     <= {8'd0, 1'b0, bus.hour};
                  mn_sr_q     <= {8'd0, bus.minute};
                  sc_sr_q     <= {8'd0, bus.second};
                  shift_cnt_q <= '0;
                  state_q     <= SHIFT;
               end
            end
            SHIFT: begin
               if (shift_cnt_q == LAST_SHIFT) begin
                  state_q <= COMMIT;
               end else begin
                  hr_sr_q     <= dd_step(hr_sr_q);
                  mn_sr_q     <= dd_step(mn_sr_q);
                  sc_sr_q     <= dd_step(sc_sr_q);
                  shift_cnt_q <= shift_cnt_q + 3'd1;
               end
            end
            COMMIT: begin
               bcd_q   <= {hr_sr_q[13:6], mn_sr_q[13:6], sc_sr_q[13:6]};
               last_q  <= snap_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef CLOCK_DISPLAY_BLINK_EN
   localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
   localparam int BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;

   logic [BLINK_W-1:0] blink_cnt_q;
   logic               phase_q;
   mode_e              mode;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (blink_cnt_q == BLINK_W'(HALF - 1)) begin
         blink_cnt_q <= '0;
         phase_q     <= ~phase_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + 1'b1;
      end
   end

   always_comb begin
      mode  = mode_e'(bus.mode);
      blank = 1'b0;
      if (phase_q) begin
         case (mode)
            MODE_HOUR: blank = (idx_q >= 3'd4);
            MODE_MIN:  blank = (idx_q == 3'd2) || (idx_q == 3'd3);
            MODE_SEC:  blank = (idx_q <= 3'd1);
            default:   blank = 1'b0;
         endcase
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{bus.mode, 32'(BLINK_HZ)};
   assign blank      = 1'b0;
`endif

   assign digit = bcd_q[{idx_q, 2'b00} +: 4];
   assign an_d  = ~(6'b000001 << idx_q);
   assign seg_d = blank ? 7'h7F : dec_seg;

   seg7_decode u_dec (
      .bcd_i (digit),
      .seg_o (dec_seg)
   );

   // an and seg share one register stage, both derived from the same idx_q.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt_q <= '0;
         idx_q      <= '0;
         an_q       <= '1;
         seg_q      <= 7'h7F;
      end else begin
         if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            idx_q      <= (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
         end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign bus.seg       = seg_q;
   assign bus.an        = an_q;
   assign bus.conv_busy = busy_q;

endmodule

// File: tb/tb_clock_display.sv
// Self-checking bench for clock_display (CLK_HZ=1000, SCAN_HZ=100, BLINK_HZ=2).
module tb_clock_display;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [41:0] sb_q[$];

   clock_display_if bus();

   clock_display #(.CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [41:0] frame_of(int h, int m, int s);
      return {seg_of(h / 10), seg_of(h % 10), seg_of(m / 10), seg_of(m % 10),
              seg_of(s / 10), seg_of(s % 10)};
   endfunction

   function automatic int idx_of(logic [5:0] an);
      case (an)
         6'b111110: return 0;  6'b111101: return 1;  6'b111011: return 2;
         6'b110111: return 3;  6'b101111: return 4;  6'b011111: return 5;
         default:   return -1;
      endcase
   endfunction

   task automatic set_time(int h, int m, int s);
      bus.hour   = 5'(h);
      bus.minute = 6'(m);
      bus.second = 6'(s);
      sb_q.push_back(frame_of(h, m, s));
   endtask

   // Samples from index j0 onward; returns first sample index with busy high and the high count.
   task automatic wait_idle(input int j0, output int rise, output int hi);
      int  j;
      bit  done;
      j = j0; done = 0; rise = -1; hi = 0;
      while (!done && j < j0 + 40) begin
         @(negedge clk);
         if (bus.conv_busy) begin
            if (rise < 0) rise = j;
            hi++;
         end else if (rise >= 0) begin
            done = 1;
         end
         j++;
      end
   endtask

   task automatic capture_frame(output logic [41:0] f, output bit ok);
      bit seen [6];
      int ix;
      f = '1;
      for (int i = 0; i < 6; i++) seen[i] = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         ix = idx_of(bus.an);
         if (ix >= 0) begin
            f[ix*7 +: 7] = bus.seg;
            seen[ix] = 1;
         end
      end
      ok = 1;
      for (int i = 0; i < 6; i++) if (!seen[i]) ok = 0;
   endtask

   task automatic check_frame(string name);
      logic [41:0] f, exp;
      bit ok;
      capture_frame(f, ok);
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         exp = sb_q.pop_front();
         if (!ok || f !== exp) begin
            errors++;
            $display("FAIL %s: frame got %h (all digits seen=%0d) expected %h", name, f, ok, exp);
         end
      end
   endtask

   task automatic test_reset();
      int rise, hi;
      rst_n = 1'b0; bus.mode = 2'd0;
      bus.hour = '0; bus.minute = '0; bus.second = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.seg !== 7'h7F || bus.an !== 6'h3F || bus.conv_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_vals: seg=%h an=%b busy=%b expected 7f 111111 0", bus.seg, bus.an, bus.conv_busy);
      end
      rst_n = 1'b1;
      sb_q.push_back(frame_of(0, 0, 0));
      @(negedge clk);
      checks++;
      if (bus.an !== 6'b111110 || bus.seg !== 7'h40 || bus.conv_busy !== 1'b0) begin
         errors++;
         $display("FAIL first_digit: an=%b seg=%h busy=%b expected 111110 40 0", bus.an, bus.seg, bus.conv_busy);
      end
      wait_idle(1, rise, hi);
      checks++;
      if (rise !== 1 || hi !== 7) begin
         errors++;
         $display("FAIL reset_conv_busy: rise=%0d high=%0d expected 1 7", rise, hi);
      end
      check_frame("reset_frame");
   endtask

   task automatic test_hms();
      int rise, hi;
      set_time(23, 45, 9);
      wait_idle(0, rise, hi);
      checks++;
      if (rise !== 1 || hi !== 7) begin
         errors++;
         $display("FAIL hms_busy: rise=%0d high=%0d expected 1 7", rise, hi);
      end
      check_frame("hms_frame");
   endtask

   task automatic test_scan();
      logic [41:0] f;
      int ix, prev, run, bad_hot, bad_seg, bad_seq, bad_dwell, runs;
      bit partial;
      f = frame_of(23, 45, 9);
      prev = -1; run = 0; partial = 1;
      bad_hot = 0; bad_seg = 0; bad_seq = 0; bad_dwell = 0; runs = 0;
      for (int c = 0; c < 130; c++) begin
         @(negedge clk);
         ix = idx_of(bus.an);
         if (ix < 0) bad_hot++;
         else if (bus.seg !== f[ix*7 +: 7]) bad_seg++;
         if (prev < 0) begin
            prev = ix; run = 1;
         end else if (ix != prev) begin
            if (ix != (prev + 1) % 6) bad_seq++;
            if (!partial) begin
               runs++;
               if (run != 10) bad_dwell++;
            end
            partial = 0; prev = ix; run = 1;
         end else begin
            run++;
         end
      end
      checks++;
      if (bad_hot != 0) begin errors++; $display("FAIL scan_onehot: %0d bad an samples, expected 0", bad_hot); end
      checks++;
      if (bad_seg != 0) begin errors++; $display("FAIL scan_seg_match: %0d seg/an mismatches, expected 0", bad_seg); end
      checks++;
      if (bad_seq != 0) begin errors++; $display("FAIL scan_order: %0d bad steps, expected 0", bad_seq); end
      checks++;
      if (bad_dwell != 0 || runs < 5) begin
         errors++;
         $display("FAIL scan_dwell: %0d runs not 10 clk out of %0d, expected 0 of >=5", bad_dwell, runs);
      end
   endtask

   task automatic test_midshift();
      logic [6:0] cur;
      logic [41:0] f13, f14;
      int rise, hi, bad_busy;
      bit found, exp_busy;
      logic [5:0] prev_an;
      set_time(0, 0, 12);
      wait_idle(0, rise, hi);
      check_frame("sec12_frame");
      // Align so that commits land inside one seconds-units dwell window.
      found = 0; prev_an = bus.an;
      for (int c = 0; c < 80 && !found; c++) begin
         @(negedge clk);
         if (bus.an == 6'b111110 && prev_an != 6'b111110) found = 1;
         prev_an = bus.an;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL midshift_sync: units digit never appeared, expected within 80 clk"); end
      repeat (50) @(negedge clk);
      set_time(0, 0, 13);
      bad_busy = 0; f13 = '0; f14 = '0;
      for (int j = 0; j <= 20; j++) begin
         @(negedge clk);
         exp_busy = (j >= 1 && j <= 7) || (j >= 10 && j <= 16);
         if (bus.conv_busy !== exp_busy) bad_busy++;
         cur = bus.seg;
         if (j == 2) set_time(0, 0, 14);
         if (j == 9) begin
            f13 = sb_q.pop_front();
            checks++;
            if (cur !== f13[6:0] || bus.an !== 6'b111110) begin
               errors++;
               $display("FAIL midshift_commit13: seg=%h an=%b expected %h 111110", cur, bus.an, f13[6:0]);
            end
         end
         if (j == 17) begin
            checks++;
            if (cur !== f13[6:0]) begin
               errors++;
               $display("FAIL midshift_hold13: seg=%h expected %h", cur, f13[6:0]);
            end
         end
         if (j == 18) begin
            f14 = sb_q.pop_front();
            checks++;
            if (cur !== f14[6:0] || bus.an !== 6'b111110) begin
               errors++;
               $display("FAIL midshift_commit14: seg=%h an=%b expected %h 111110", cur, bus.an, f14[6:0]);
            end
         end
      end
      checks++;
      if (bad_busy != 0) begin errors++; $display("FAIL midshift_busy: %0d busy mismatches, expected 0", bad_busy); end
   endtask

   task automatic test_overflow_reset();
      int rise, hi;
      logic [41:0] stale;
      set_time(31, 0, 63);
      wait_idle(0, rise, hi);
      check_frame("overflow_frame");
      set_time(31, 0, 5);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.seg !== 7'h7F || bus.an !== 6'h3F || bus.conv_busy !== 1'b0) begin
         errors++;
         $display("FAIL midshift_reset: seg=%h an=%b busy=%b expected 7f 111111 0", bus.seg, bus.an, bus.conv_busy);
      end
      rst_n = 1'b1;
      wait_idle(0, rise, hi);
      checks++;
      if (rise !== 1 || hi !== 7) begin
         errors++;
         $display("FAIL reconvert_busy: rise=%0d high=%0d expected 1 7", rise, hi);
      end
      check_frame("reconvert_frame");
      stale = frame_of(31, 0, 63);
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, expected 0 (stale %h)", sb_q.size(), stale); end
   endtask

   task automatic test_mode();
      logic [41:0] f;
      int rise, hi, ix, bad, blank_n, vis_n, last_chg, diffs, bad_diff;
      bit state, have_state;
      bus.mode = 2'd2;
      set_time(0, 7, 0);
      wait_idle(0, rise, hi);
      f = sb_q.pop_front();
`ifdef CLOCK_DISPLAY_BLINK_EN
      bad = 0; blank_n = 0; vis_n = 0; have_state = 0; state = 0;
      last_chg = -1; diffs = 0; bad_diff = 0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         ix = idx_of(bus.an);
         if (ix == 2 || ix == 3) begin
            if (bus.seg === 7'h7F) blank_n++;
            else if (bus.seg === f[ix*7 +: 7]) vis_n++;
            else bad++;
            if (have_state && (bus.seg === 7'h7F) != state) begin
               if (last_chg >= 0) begin
                  diffs++;
                  if (c - last_chg < 200 || c - last_chg > 300) bad_diff++;
               end
               last_chg = c;
            end
            state = (bus.seg === 7'h7F); have_state = 1;
         end else if (ix >= 0 && bus.seg !== f[ix*7 +: 7]) begin
            bad++;
         end
      end
      checks++;
      if (blank_n == 0 || vis_n == 0) begin
         errors++;
         $display("FAIL blink_phases: blank=%0d visible=%0d expected both >0", blank_n, vis_n);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL blink_values: %0d wrong segs, expected 0", bad); end
      checks++;
      if (diffs == 0 || bad_diff != 0) begin
         errors++;
         $display("FAIL blink_period: %0d of %0d intervals outside 250+-50, expected 0 of >0", bad_diff, diffs);
      end
`else
      bad = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         ix = idx_of(bus.an);
         if (ix >= 0 && bus.seg !== f[ix*7 +: 7]) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL mode_ignored: %0d wrong segs with mode=2, expected 0", bad); end
`endif
      bus.mode = 2'd0;
      bad = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         ix = idx_of(bus.an);
         if (ix < 0 || bus.seg !== f[ix*7 +: 7]) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL run_mode_visible: %0d wrong segs with mode=0, expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_hms();
      test_scan();
      test_midshift();
      test_overflow_reset();
      test_mode();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
